// File: rtl/adder_seq_pkg.sv
// Shared types and defaults for the adder operand sequencer.
// Optional build macro: OPERAND_ZEROIZE_EN.
package adder_seq_pkg;

  localparam int CHUNK_W_DEF = 16;
  localparam int OPW_DEF     = 64;
  localparam int ADD_LAT_DEF = 1;
  localparam int BEATS_DEF   = OPW_DEF / CHUNK_W_DEF;

  typedef enum logic [1:0] {
    LOAD_A,
    LOAD_B,
    WAIT,
    RESULT
  } state_e;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int CNT_W_DEF = cnt_w(BEATS_DEF);

endpackage

// File: rtl/adder_operand_sequencer_chunk_assembler.sv
// Operand register filled one chunk at a time by beat index.
// Optional build macro: OPERAND_ZEROIZE_EN (drives clr_i from the top).
module chunk_assembler #(
  parameter int W  = 64,
  parameter int CW = 16,
  parameter int IW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          we_i,
  input  logic [IW-1:0] idx_i,
  input  logic [CW-1:0] data_i,
  output logic [W-1:0]  q_o
);

  localparam int N = W / CW;

  logic [W-1:0] q_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else if (clr_i) begin
      q_q <= '0;
    end else if (we_i) begin
      for (int k = 0; k < N; k++) begin
        if (idx_i == IW'(k)) begin
          q_q[k*CW +: CW] <= data_i;
        end
      end
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/adder_operand_sequencer.sv
// Feeds chunked operands to an external adder and returns its result.
// Optional build macro: OPERAND_ZEROIZE_EN clears data after result handshake.
module adder_operand_sequencer
  import adder_seq_pkg::*;
#(
  parameter int CHUNK_W = CHUNK_W_DEF,
  parameter int OPW     = OPW_DEF,
  parameter int ADD_LAT = ADD_LAT_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CHUNK_W-1:0] in_data,
  output logic [OPW-1:0]     add_a,
  output logic [OPW-1:0]     add_b,
  input  logic [OPW-1:0]     add_sum,
  input  logic               add_carry,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [OPW-1:0]     res_sum,
  output logic               res_carry,
  output logic               busy
);

  localparam int BEATS = OPW / CHUNK_W;
  localparam int CW    = cnt_w(BEATS);
  localparam int WW    = cnt_w(ADD_LAT + 1);
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);
  localparam logic [WW-1:0] WEND = WW'(ADD_LAT);

  state_e           state_q;
  logic [CW-1:0]    beat_q;
  logic [WW-1:0]    wcnt_q;
  logic [OPW-1:0]   res_sum_q;
  logic             res_carry_q;
  logic             res_valid_q;
  logic             busy_q;
  logic             a_we;
  logic             b_we;
  logic             res_hs;
  logic             zclr;

  assign in_ready = (state_q == LOAD_A) || (state_q == LOAD_B);
  assign a_we     = (state_q == LOAD_A) && in_valid;
  assign b_we     = (state_q == LOAD_B) && in_valid;
  assign res_hs   = (state_q == RESULT) && res_ready;

`ifdef OPERAND_ZEROIZE_EN
  assign zclr = res_hs;
`else
  assign zclr = 1'b0;
`endif

  chunk_assembler #(
    .W (OPW),
    .CW(CHUNK_W),
    .IW(CW)
  ) u_asm_a (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (zclr),
    .we_i  (a_we),
    .idx_i (beat_q),
    .data_i(in_data),
    .q_o   (add_a)
  );

  chunk_assembler #(
    .W (OPW),
    .CW(CHUNK_W),
    .IW(CW)
  ) u_asm_b (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (zclr),
    .we_i  (b_we),
    .idx_i (beat_q),
    .data_i(in_data),
    .q_o   (add_b)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LOAD_A;
      beat_q      <= '0;
      wcnt_q      <= '0;
      res_sum_q   <= '0;
      res_carry_q <= 1'b0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        LOAD_A: begin
          if (in_valid) begin
            if (beat_q == LAST) begin
              beat_q  <= '0;
              state_q <= LOAD_B;
            end else begin
              beat_q <= beat_q + CW'(1);
            end
          end
        end
        LOAD_B: begin
          if (in_valid) begin
            if (beat_q == LAST) begin
              beat_q  <= '0;
              wcnt_q  <= '0;
              busy_q  <= 1'b1;
              state_q <= WAIT;
            end else begin
              beat_q <= beat_q + CW'(1);
            end
          end
        end
        WAIT: begin
          // sample only once the adder pipeline has drained the new operands
          if (wcnt_q == WEND) begin
            res_sum_q   <= add_sum;
            res_carry_q <= add_carry;
            res_valid_q <= 1'b1;
            state_q     <= RESULT;
          end else begin
            wcnt_q <= wcnt_q + WW'(1);
          end
        end
        RESULT: begin
          if (res_ready) begin
            beat_q      <= '0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= LOAD_A;
`ifdef OPERAND_ZEROIZE_EN
            res_sum_q   <= '0;
            res_carry_q <= 1'b0;
`endif
          end
        end
        default: state_q <= LOAD_A;
      endcase
    end
  end

  assign res_valid = res_valid_q;
  assign res_sum   = res_sum_q;
  assign res_carry = res_carry_q;
  assign busy      = busy_q;

endmodule
